// File: rtl/fsk_framer_pkg.sv
// Shared types and constants for the FSK bit framer.
// Latency: n/a (declarations only).
// Backpressure: n/a. FSK_PARITY_EN adds one parity symbol per frame.
package fsk_framer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } framer_state_t;

  localparam int DIV_W_DEF  = 16;
  localparam int DATA_W_DEF = 8;

  // Symbols in one frame: start + data + [parity] + stop.
  function automatic int frame_syms(input int data_w);
`ifdef FSK_PARITY_EN
    return data_w + 3;
`else
    return data_w + 2;
`endif
  endfunction

  localparam int FRAME_SYMS = frame_syms(DATA_W_DEF);

endpackage

// File: rtl/fsk_baud_timer.sv
// Symbol-period down-counter: a load starts a symbol of load_val+1 cycles.
// Latency: sym_first is high the cycle after a load; sym_last is high in the final cycle.
// Backpressure: none; the framer decides when to reload.
module fsk_baud_timer
  import fsk_framer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             sym_first,
  output logic             sym_last
);

  logic [DIV_W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      sym_first <= 1'b0;
    end else begin
      sym_first <= load;
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign sym_last = (cnt == '0);

endmodule

// File: rtl/fsk_bit_framer.sv
// Serialises AXIS bytes into start/data(LSB first)/[parity]/stop symbols of cfg_div+1 cycles.
// Latency: START begins the cycle after the handshake; back-to-back frames have no idle gap.
// Backpressure: tready only in IDLE or last STOP cycle with cfg_enable. Parity via FSK_PARITY_EN.
module fsk_bit_framer
  import fsk_framer_pkg::*;
#(
  parameter int   DIV_W    = DIV_W_DEF,
  parameter int   DATA_W   = DATA_W_DEF,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_enable,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_parity_odd,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              tx_bit,
  output logic              tx_sym_stb,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  framer_state_t         state, state_d;
  logic [DATA_W-1:0]     sr, sr_d;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tx_bit_q, tx_bit_d;
  logic                  out_of_reset;
  logic                  hs;
  logic                  tmr_load;
  logic [DIV_W-1:0]      tmr_val;
  logic                  sym_first;
  logic                  sym_last;

`ifdef FSK_PARITY_EN
  logic                  par_q, par_d;
`else
  logic                  unused_parity;
  assign unused_parity = cfg_parity_odd;
`endif

  // out_of_reset keeps tready low on every edge that sees reset asserted.
  assign s_axis_tready = out_of_reset & cfg_enable &
                         ((state == IDLE) | ((state == STOP) & sym_last));
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign tx_bit        = tx_bit_q;
  assign tx_sym_stb    = sym_first;
  assign tx_active     = (state != IDLE);
  assign frame_done    = (state == STOP) & sym_last;

  fsk_baud_timer #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .sym_first (sym_first),
    .sym_last  (sym_last)
  );

  // Next state, next symbol level and timer reload, advancing on symbol boundaries.
  always_comb begin
    state_d   = state;
    sr_d      = sr;
    bit_cnt_d = bit_cnt;
    div_d     = div_q;
    tx_bit_d  = tx_bit_q;
    tmr_load  = 1'b0;
    tmr_val   = div_q;
`ifdef FSK_PARITY_EN
    par_d     = par_q;
`endif

    case (state)
      IDLE: begin
        state_d = IDLE;
      end
      START: begin
        if (sym_last) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_bit_d  = sr[0];
          tmr_load  = 1'b1;
        end
      end
      DATA: begin
        if (sym_last) begin
          tmr_load = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef FSK_PARITY_EN
            state_d  = PARITY;
            tx_bit_d = par_q;
`else
            state_d  = STOP;
            tx_bit_d = IDLE_LVL;
`endif
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
            sr_d      = sr >> 1;
            tx_bit_d  = sr_d[0];
          end
        end
      end
`ifdef FSK_PARITY_EN
      PARITY: begin
        if (sym_last) begin
          state_d  = STOP;
          tx_bit_d = IDLE_LVL;
          tmr_load = 1'b1;
        end
      end
`endif
      STOP: begin
        if (sym_last) begin
          state_d  = IDLE;
          tx_bit_d = IDLE_LVL;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_bit_d = IDLE_LVL;
      end
    endcase

    // An accepted byte (from IDLE or the last STOP cycle) always starts a new frame.
    if (hs) begin
      state_d   = START;
      sr_d      = s_axis_tdata;
      div_d     = cfg_div;
      bit_cnt_d = '0;
      tx_bit_d  = ~IDLE_LVL;
      tmr_load  = 1'b1;
      tmr_val   = cfg_div;
`ifdef FSK_PARITY_EN
      par_d     = (^s_axis_tdata) ^ cfg_parity_odd;
`endif
    end
  end

  // Frame state registers; reset abandons any frame in flight.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      div_q        <= '0;
      tx_bit_q     <= IDLE_LVL;
      out_of_reset <= 1'b0;
`ifdef FSK_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      sr           <= sr_d;
      bit_cnt      <= bit_cnt_d;
      div_q        <= div_d;
      tx_bit_q     <= tx_bit_d;
      out_of_reset <= 1'b1;
`ifdef FSK_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fsk_bit_framer.sv
// Self-checking bench for fsk_bit_framer: waveform-queue model plus literal frame checks.
// Latency: n/a.
// Backpressure: drives AXIS with tvalid held until accepted.
`timescale 1ns/1ps
module tb_fsk_bit_framer;

`ifdef FSK_PARITY_EN
  localparam int NS = 11;
`else
  localparam int NS = 10;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic        cfg_parity_odd = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        tx_bit;
  logic        tx_sym_stb;
  logic        tx_active;
  logic        frame_done;

  fsk_bit_framer dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .cfg_enable     (cfg_enable),
    .cfg_div        (cfg_div),
    .cfg_parity_odd (cfg_parity_odd),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .tx_bit         (tx_bit),
    .tx_sym_stb     (tx_sym_stb),
    .tx_active      (tx_active),
    .frame_done     (frame_done)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected output waveform, one entry per cycle, front = current cycle.
  typedef struct packed {
    logic b;
    logic stb;
    logic done;
  } ent_t;

  ent_t q[$];
  bit   armed_m = 1'b0;

  function automatic void push_frame(input logic [7:0] d, input int p, input logic odd);
    logic syms[$];
    ent_t e;
    logic par;
    par = (^d) ^ odd;
    syms.push_back(1'b0);
    for (int i = 0; i < 8; i++) syms.push_back(d[i]);
`ifdef FSK_PARITY_EN
    syms.push_back(par);
`endif
    syms.push_back(1'b1);
    for (int s = 0; s < syms.size(); s++) begin
      for (int c = 0; c < p; c++) begin
        e.b    = syms[s];
        e.stb  = (c == 0);
        e.done = (s == syms.size() - 1) && (c == p - 1);
        q.push_back(e);
      end
    end
  endfunction

  always @(posedge ACLK) begin : model_upd
    bit acc;
    if (!ARESETN) begin
      q.delete();
      armed_m = 1'b0;
    end else begin
      acc = armed_m && cfg_enable && (q.size() <= 1) && s_axis_tvalid;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) push_frame(s_axis_tdata, int'(cfg_div) + 1, cfg_parity_odd);
      armed_m = 1'b1;
    end
  end

  always @(negedge ACLK) begin : compare
    logic ea, eb, es, ed, er;
    if (cmp_en) begin
      ea = (q.size() > 0);
      eb = ea ? q[0].b : 1'b1;
      es = ea ? q[0].stb : 1'b0;
      ed = ea ? q[0].done : 1'b0;
      er = armed_m && cfg_enable && (q.size() <= 1);
      chk("cyc_tx_active", tx_active, ea);
      chk("cyc_tx_bit", tx_bit, eb);
      chk("cyc_tx_sym_stb", tx_sym_stb, es);
      chk("cyc_frame_done", frame_done, ed);
      chk("cyc_tready", s_axis_tready, er);
    end
  end

  // Observation counters for the literal checks.
  int   act_cnt, stb_cnt, done_cnt, done_at, rdy_act, rdy_nodone, rdy_seen, rise_cnt;
  logic act_prev = 1'b0;
  logic sym_q[$];

  always @(negedge ACLK) begin
    if (tx_active === 1'b1) act_cnt++;
    if (tx_active === 1'b1 && act_prev !== 1'b1) rise_cnt++;
    act_prev = tx_active;
    if (tx_sym_stb === 1'b1) begin
      stb_cnt++;
      sym_q.push_back(tx_bit);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_at = act_cnt;
    end
    if (s_axis_tready === 1'b1) rdy_seen++;
    if (s_axis_tready === 1'b1 && tx_active === 1'b1) rdy_act++;
    if (s_axis_tready === 1'b1 && tx_active === 1'b1 && frame_done !== 1'b1) rdy_nodone++;
  end

  task automatic mon_clear();
    act_cnt = 0; stb_cnt = 0; done_cnt = 0; done_at = 0;
    rdy_act = 0; rdy_nodone = 0; rdy_seen = 0; rise_cnt = 0;
    sym_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // Present a byte and return just after the edge that accepts it; tvalid stays high.
  task automatic offer(input logic [7:0] d, input string name);
    int k;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    k = 0;
    do begin
      @(negedge ACLK);
      k++;
    end while (s_axis_tready !== 1'b1 && k < 2000);
    chk({name, "_timeout"}, (k < 2000), 1'b1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge ACLK);
      k++;
    end while (tx_active !== 1'b0 && k < 2000);
    chk({name, "_timeout"}, (k < 2000), 1'b1);
    @(posedge ACLK);
    #1;
  endtask

  // Symbols seen at each strobe, first symbol in the MSB of the n-bit literal.
  task automatic check_syms(input string name, input logic [63:0] exp, input int n);
    logic [63:0] obs;
    obs = '0;
    chk({name, "_count"}, sym_q.size(), n);
    for (int i = 0; i < n && i < sym_q.size(); i++) obs[n-1-i] = sym_q[i];
    chk(name, obs, exp);
  endtask

  // 10-symbol literal; with parity an even-parity bit (0) sits before stop (all such bytes here are even).
  function automatic logic [NS-1:0] lit(input logic [9:0] v);
`ifdef FSK_PARITY_EN
    return {v[9:1], 1'b0, v[0]};
`else
    return v;
`endif
  endfunction

  initial begin
    ARESETN = 1'b0;
    tick(3);
    cmp_en = 1'b1;
    chk("rst_tx_bit", tx_bit, 1'b1);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_stb", tx_sym_stb, 1'b0);
    chk("rst_active", tx_active, 1'b0);
    chk("rst_done", frame_done, 1'b0);

    ARESETN = 1'b1;
    cfg_enable = 1'b1;
    cfg_div = 16'd3;
    tick(2);

    // Single byte 0xA5, P=4.
    mon_clear();
    offer(8'hA5, "a5_hs");
    s_axis_tvalid = 1'b0;
    wait_idle("a5_end");
    check_syms("a5_syms", lit(10'b0101001011), NS);
    chk("a5_stb_cnt", stb_cnt, NS);
    chk("a5_active", act_cnt, NS * 4);
    chk("a5_done_at", done_at, NS * 4);
    chk("a5_done_cnt", done_cnt, 1);

    // Back-to-back 0x00 then 0xFF, P=1, tvalid held.
    cfg_div = 16'd0;
    tick(1);
    mon_clear();
    offer(8'h00, "b2b_hs1");
    offer(8'hFF, "b2b_hs2");
    s_axis_tvalid = 1'b0;
    wait_idle("b2b_end");
    check_syms("b2b_syms", {lit(10'b0000000001), lit(10'b0111111111)}, 2 * NS);
    chk("b2b_active", act_cnt, 2 * NS);
    chk("b2b_no_gap", rise_cnt, 1);
    chk("b2b_rdy_at_stop", rdy_act, 2);
    chk("b2b_rdy_early", rdy_nodone, 0);
    chk("b2b_done_cnt", done_cnt, 2);

    // Disable during DATA of 0x3C with a pending byte, P=2.
    cfg_div = 16'd1;
    tick(1);
    mon_clear();
    offer(8'h3C, "dis_hs");
    s_axis_tvalid = 1'b0;
    tick(6);
    cfg_enable = 1'b0;
    s_axis_tdata = 8'h55;
    s_axis_tvalid = 1'b1;
    rdy_seen = 0;
    wait_idle("dis_end");
    tick(10);
    check_syms("dis_syms", lit(10'b0001111001), NS);
    chk("dis_active", act_cnt, NS * 2);
    chk("dis_rdy_held_low", rdy_seen, 0);
    chk("dis_no_new_frame", rise_cnt, 1);
    mon_clear();
    cfg_enable = 1'b1;
    offer(8'h55, "reen_hs");
    s_axis_tvalid = 1'b0;
    wait_idle("reen_end");
    check_syms("reen_syms", lit(10'b0101010101), NS);

    // Reset during data bit 4, then a fresh 0x81, P=4.
    cfg_div = 16'd3;
    tick(1);
    mon_clear();
    offer(8'hFF, "rst_hs");
    s_axis_tvalid = 1'b0;
    tick(21);
    chk("mid_active", tx_active, 1'b1);
    chk("mid_sym_idx", sym_q.size(), 6);
    ARESETN = 1'b0;
    tick(1);
    chk("mid_rst_tx_bit", tx_bit, 1'b1);
    chk("mid_rst_active", tx_active, 1'b0);
    chk("mid_rst_tready", s_axis_tready, 1'b0);
    tick(2);
    ARESETN = 1'b1;
    tick(2);
    mon_clear();
    offer(8'h81, "post_rst_hs");
    s_axis_tvalid = 1'b0;
    wait_idle("post_rst_end");
    check_syms("post_rst_syms", lit(10'b0100000011), NS);
    chk("post_rst_active", act_cnt, NS * 4);

`ifdef FSK_PARITY_EN
    // Parity of 0x07, P=2.
    cfg_div = 16'd1;
    cfg_parity_odd = 1'b0;
    tick(1);
    mon_clear();
    offer(8'h07, "par_even_hs");
    s_axis_tvalid = 1'b0;
    wait_idle("par_even_end");
    check_syms("par_even_syms", 11'b01110000011, 11);
    chk("par_even_active", act_cnt, 22);
    cfg_parity_odd = 1'b1;
    tick(1);
    mon_clear();
    offer(8'h07, "par_odd_hs");
    s_axis_tvalid = 1'b0;
    wait_idle("par_odd_end");
    check_syms("par_odd_syms", 11'b01110000001, 11);
    chk("par_odd_active", act_cnt, 22);
    cfg_parity_odd = 1'b0;
`endif

    // cfg_div changes mid-frame: current frame keeps P=4, next uses P=8.
    cfg_div = 16'd3;
    tick(1);
    mon_clear();
    offer(8'h5A, "lat1_hs");
    s_axis_tvalid = 1'b0;
    tick(5);
    cfg_div = 16'd7;
    wait_idle("lat1_end");
    check_syms("lat1_syms", lit(10'b0010110101), NS);
    chk("lat1_active", act_cnt, NS * 4);
    mon_clear();
    offer(8'hC3, "lat2_hs");
    s_axis_tvalid = 1'b0;
    wait_idle("lat2_end");
    check_syms("lat2_syms", lit(10'b0110000111), NS);
    chk("lat2_active", act_cnt, NS * 8);
    chk("lat2_done_at", done_at, NS * 8);

    tick(3);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_bit_framer.md
Name: fsk_bit_framer

Overview:
- Upstream stage of the FSK modulator. Accepts bytes on an AXI4-Stream slave and serialises each one into an asynchronous frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Drives one symbol bit plus a symbol strobe into the modulator's bit input, at a programmable symbol period.
- Configuration comes from the modulator's AXI-Lite register bank.

Parameters:
- DIV_W, 16, width of symbol-period divider.
- DATA_W, 8, data bits per frame.
- IDLE_LVL, 1'b1, tx_bit level while idle and during the stop bit.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  reset; synchronous, active-low.
- cfg_enable  in  1  allow acceptance of new frames.
- cfg_div  in  DIV_W  symbol period minus one, in ACLK cycles.
- cfg_parity_odd  in  1  parity sense: 1 = odd, 0 = even. Used only with FSK_PARITY_EN.
- s_axis_tdata  in  DATA_W  byte to send.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  framer can accept a byte.
- tx_bit  out  1  current symbol to the modulator.
- tx_sym_stb  out  1  one-cycle pulse on the first cycle of every symbol.
- tx_active  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: all outputs are forced on the next ACLK edge with ARESETN=0.
  - tx_bit=IDLE_LVL; s_axis_tready, tx_sym_stb, tx_active, frame_done = 0.
  - State is IDLE; counters are cleared.
- Reset mid-frame: the frame is abandoned and no partial byte is resumed.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when chaining frames.
- Symbol period: P = cfg_div+1 cycles.
  - cfg_div is latched on byte acceptance and held for the whole frame.
  - cfg_div=0 gives P=1, one symbol per cycle; this is legal.
- s_axis_tready is asserted in two cases:
  - in IDLE with cfg_enable=1;
  - in the last cycle of STOP with cfg_enable=1.
  - It is registered-state derived with no combinational path from tvalid.
- Handshake (tvalid & tready): tdata goes to a shift register, parity is computed, and the state moves to START on the next cycle.
- START:
  - tx_bit=~IDLE_LVL for P cycles.
  - tx_sym_stb=1 on its first cycle; tx_active=1 from this cycle onward.
- DATA:
  - DATA_W symbols, each of P cycles, LSB first; the shift register shifts right at each symbol boundary.
  - A bit counter runs 0..DATA_W-1.
  - tx_sym_stb pulses at the start of every symbol.
- STOP:
  - tx_bit=IDLE_LVL for P cycles; frame_done=1 on its last cycle.
  - If a handshake occurs that cycle, the next cycle is START of the new frame with no idle gap (back-to-back).
  - Otherwise go to IDLE with tx_active=0.
- Frame length: (DATA_W+2)*P cycles, or (DATA_W+3)*P with parity.
- cfg_enable dropped mid-frame: the current frame completes normally and no further byte is accepted.
- tvalid held without a handshake: data is ignored until tready is asserted; AXIS rules apply and tdata must be stable while tvalid is high.
- tx_bit and tx_sym_stb are registered and change together on symbol boundaries.

Optional Feature:
- Macro: FSK_PARITY_EN.
- Defined:
  - The PARITY state is inserted between DATA and STOP, lasting one symbol.
  - tx_bit = XOR of the data bits, XORed with cfg_parity_odd.
  - tx_sym_stb pulses at the start of the parity symbol.
- Undefined:
  - The PARITY state and parity logic are absent; DATA goes directly to STOP.
  - cfg_parity_odd is ignored (port kept, unused).

Decomposition:
- Package fsk_framer_pkg holds:
  - state enum framer_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam FRAME_SYMS (function of DATA_W and FSK_PARITY_EN);
  - default DIV_W.
- Sub-module fsk_baud_timer:
  - loadable down-counter from the latched cfg_div;
  - outputs sym_first and sym_last pulses;
  - restarts on frame start and on each symbol boundary.

Test Plan:
- Single byte: cfg_div=3, enable=1, send 0xA5.
  - tx_bit sequence per 4-cycle symbol: 0,1,0,1,0,0,1,0,1,1.
  - 10 tx_sym_stb pulses, 40 cycles with tx_active=1, frame_done at cycle 40.
- Back-to-back: 0x00 then 0xFF with tvalid held high, cfg_div=0.
  - Second START immediately follows the first STOP.
  - tready pulses exactly at the last STOP cycle; total 20 active cycles.
- Disable mid-frame: drop cfg_enable during DATA of 0x3C.
  - The frame completes correctly and tready stays 0 afterwards.
  - A pending tvalid is not accepted until re-enable.
- Reset mid-frame: assert ARESETN=0 during bit 4.
  - Next cycle: tx_bit=1, tx_active=0, tready=0.
  - After release a fresh frame of 0x81 is sent correctly.
- Parity (FSK_PARITY_EN defined), cfg_div=1:
  - send 0x07 with odd=0: parity bit is 1;
  - send 0x07 with odd=1: parity bit is 0;
  - each frame is 22 cycles.
- Config latch: change cfg_div from 3 to 7 mid-frame.
  - The current frame keeps P=4.
  - The next frame uses P=8.
